toy_lsu_resp_merge: RTL

Response-side counterpart of the LSU dtcm/dcache request decoder. It records the target (dtcm or dcache) of every accepted load/store request in program order. It buffers the responses returned independently by the dtcm and the dcache, and releases them to the LSU writeback in the original request order through one registered valid/ready port. It also throttles the decoder when the order tracker is full and flags responses that have no matching outstanding request.

---
 rtl/toy_lsu_resp_merge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/toy_lsu_resp_merge.sv
// toy_lsu_resp_merge
// Tracks the target (dtcm/dcache) of every accepted LSU request in program
// order, buffers the responses each target returns, and re-issues them to
// the LSU writeback in request order through one registered valid/ready port.
module toy_lsu_resp_merge #(
    parameter int RESP_W     = 64,
    parameter int ORD_DEPTH  = 8,
    parameter int RESP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_vld_dtcm,
    input  logic                         req_rdy_dtcm,
    input  logic                         req_vld_dcache,
    input  logic                         req_rdy_dcache,
    output logic                         req_allow,
    input  logic                         dtcm_resp_vld,
    output logic                         dtcm_resp_rdy,
    input  logic [RESP_W-1:0]            dtcm_resp_pld,
    input  logic                         dcache_resp_vld,
    output logic                         dcache_resp_rdy,
    input  logic [RESP_W-1:0]            dcache_resp_pld,
    output logic                         m_vld,
    input  logic                         m_rdy,
    output logic [RESP_W-1:0]            m_pld,
    output logic                         err_unexp,
    output logic [$clog2(ORD_DEPTH):0]   outstanding
);

    localparam int OAW = $clog2(ORD_DEPTH);
    localparam int RAW = $clog2(RESP_DEPTH);
    localparam int CW  = OAW + 1;

    // Source index 0 = dtcm, 1 = dcache (also the tag stored in the order FIFO).
    logic [1:0]             src_vld;
    logic [1:0][RESP_W-1:0] src_pld;
    logic [1:0]             src_full;
    logic [1:0]             src_empty;
    logic [1:0]             src_push;
    logic [1:0]             src_pop;
    logic [1:0]             src_unexp;
    logic [1:0][RESP_W-1:0] src_head;

    logic [OAW:0] ord_wr_q;
    logic [OAW:0] ord_rd_q;
    logic         ord_mem_q [ORD_DEPTH];
    logic         ord_full;
    logic         ord_empty;
    logic         head_tag;

    logic         fire_t;
    logic         fire_c;
    logic         req_fire;
    logic         push_tag;
    logic         ord_push;
    logic         ord_drop;
    logic         load;
    logic         sel_empty;

    logic              m_vld_q;
    logic [RESP_W-1:0] m_pld_q;
    logic              err_q;
    logic              err_d;

    assign src_vld = {dcache_resp_vld, dtcm_resp_vld};
    assign src_pld = {dcache_resp_pld, dtcm_resp_pld};

    // The decoder never fires both targets at once; if it does, dtcm wins.
    assign fire_t   = req_vld_dtcm & req_rdy_dtcm;
    assign fire_c   = req_vld_dcache & req_rdy_dcache & ~fire_t;
    assign req_fire = fire_t | fire_c;
    assign push_tag = ~fire_t;

    assign ord_full  = (ord_wr_q[OAW] != ord_rd_q[OAW]) &&
                       (ord_wr_q[OAW-1:0] == ord_rd_q[OAW-1:0]);
    assign ord_empty = (ord_wr_q == ord_rd_q);
    assign head_tag  = ord_mem_q[ord_rd_q[OAW-1:0]];

    // Only the source named by the oldest request may feed the output slot.
    assign sel_empty = head_tag ? src_empty[1] : src_empty[0];
    assign load      = ~ord_empty & ~sel_empty & (~m_vld_q | m_rdy);

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign ord_push = req_fire & (~ord_full | load);
    assign ord_drop = req_fire & ord_full & ~load;

    // Readiness uses pre-pop fullness so m_rdy never reaches these outputs.
    assign req_allow       = ~ord_full;
    assign dtcm_resp_rdy   = ~src_full[0];
    assign dcache_resp_rdy = ~src_full[1];

    assign m_vld       = m_vld_q;
    assign m_pld       = m_pld_q;
    assign err_unexp   = err_q;
    assign outstanding = ord_wr_q - ord_rd_q;

    // Order FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ord_wr_q <= '0;
            ord_rd_q <= '0;
        end else begin
            if (ord_push) ord_wr_q <= ord_wr_q + 1'b1;
            if (load)     ord_rd_q <= ord_rd_q + 1'b1;
        end
    end

    // Order FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (ord_push) ord_mem_q[ord_wr_q[OAW-1:0]] <= push_tag;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic [RAW:0]        wr_q;
        logic [RAW:0]        rd_q;
        logic [RESP_W-1:0]   mem_q [RESP_DEPTH];
        logic [CW-1:0]       cnt_q;
        logic [CW-1:0]       cnt_d;
        logic                inc;
        logic                dec;

        assign src_full[gi]  = (wr_q[RAW] != rd_q[RAW]) &&
                               (wr_q[RAW-1:0] == rd_q[RAW-1:0]);
        assign src_empty[gi] = (wr_q == rd_q);
        assign src_head[gi]  = mem_q[rd_q[RAW-1:0]];
        assign src_push[gi]  = src_vld[gi] & ~src_full[gi];
        assign src_pop[gi]   = load & (head_tag == 1'(gi));

        assign inc           = ord_push & (push_tag == 1'(gi));
        assign dec           = src_push[gi];
        assign src_unexp[gi] = dec & (cnt_q == '0);

        // Requests still awaiting a response from this source; saturates at 0.
        always_comb begin
            cnt_d = cnt_q + CW'(inc) - CW'(dec & ~src_unexp[gi]);
        end

        // Response FIFO pointers and outstanding counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (src_push[gi]) wr_q <= wr_q + 1'b1;
                if (src_pop[gi])  rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end

        // Response FIFO storage.
        always_ff @(posedge clk) begin
            if (src_push[gi]) mem_q[wr_q[RAW-1:0]] <= src_pld[gi];
        end
    end

    // Sticky error: dropped request push or response with nothing outstanding.
    always_comb begin
        err_d = err_q | ord_drop | (|src_unexp);
    end

    // Registered output slot: load the in-order head, otherwise drain on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q <= 1'b0;
            m_pld_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            if (load) begin
                m_vld_q <= 1'b1;
                m_pld_q <= head_tag ? src_head[1] : src_head[0];
            end else if (m_rdy) begin
                m_vld_q <= 1'b0;
            end
        end
    end

endmodule
